// File: rtl/mem_cmd_port_gen_if.sv
// Bundle of NoC, descriptor, stream and ack-bus signals for the memory port.
// master = the command port, slave = its environment (NoC, FSM, ack bus).
interface mem_cmd_port_gen_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 9
);
    logic              in_bus_valid;
    logic [7:0]        in_bus_data;
    logic              out_bus_ready;
    logic              out_bus_valid;
    logic [7:0]        out_bus_data;
    logic              in_bus_ready;
    logic              fsm_cmd_valid;
    logic              fsm_cmd_ready;
    logic              fsm_rw;
    logic              fsm_enc;
    logic [ADDR_W-1:0] fsm_addr;
    logic [LEN_W-1:0]  fsm_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [7:0]        wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [7:0]        rd_data;
    logic              fsm_done;
    logic              in_ack_valid;
    logic [1:0]        in_ack_src;
    logic              in_ack_grant;
    logic              out_ack_req;
    logic [1:0]        out_ack_id;
    logic              busy;
    logic              err;

    modport master (
        input  in_bus_valid, in_bus_data, in_bus_ready,
        input  fsm_cmd_ready, wr_ready, rd_valid, rd_data,
        input  fsm_done, in_ack_valid, in_ack_src, in_ack_grant,
        output out_bus_ready, out_bus_valid, out_bus_data,
        output fsm_cmd_valid, fsm_rw, fsm_enc, fsm_addr, fsm_len,
        output wr_valid, wr_data, rd_ready,
        output out_ack_req, out_ack_id, busy, err
    );

    modport slave (
        output in_bus_valid, in_bus_data, in_bus_ready,
        output fsm_cmd_ready, wr_ready, rd_valid, rd_data,
        output fsm_done, in_ack_valid, in_ack_src, in_ack_grant,
        input  out_bus_ready, out_bus_valid, out_bus_data,
        input  fsm_cmd_valid, fsm_rw, fsm_enc, fsm_addr, fsm_len,
        input  wr_valid, wr_data, rd_ready,
        input  out_ack_req, out_ack_id, busy, err
    );
endinterface

// File: rtl/mem_cmd_port_gen.sv
// Memory-side NoC command port: header/address decode, descriptor issue,
// zero-latency payload passthrough, ack closing with receive watchdog.
module mem_cmd_port_gen #(
    parameter int         ADDR_BYTES  = 3,
    parameter int         LEN_W       = 9,
    parameter logic [1:0] MEM_ID      = 2'd0,
    parameter logic [1:0] SHA_ID      = 2'd1,
    parameter logic [1:0] AES_ID      = 2'd2,
    parameter logic [1:0] CTRL_ID     = 2'd3,
    parameter int         KEY_BEATS   = 32,
    parameter int         SHA_BEATS   = 32,
    parameter int         AES_BEATS   = 16,
    parameter int         ACK_TIMEOUT = 1024
) (
    input logic              clk,
    input logic              rst_n,
    mem_cmd_port_gen_if.master bus
);
    localparam int ADDR_W = 8 * ADDR_BYTES;
    localparam int IDX_W  = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int WD_W   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] OP_KEY  = 2'd0;
    localparam logic [1:0] OP_TEXT = 2'd1;
    localparam logic [1:0] OP_WR   = 2'd2;
    localparam logic [1:0] OP_HASH = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ISSUE,
        S_WDATA,
        S_WDONE,
        S_RDATA,
        S_ACK_RX,
        S_ACK_TX
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [LEN_W-1:0]  cnt;
    logic [WD_W-1:0]   wd;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic              rw_q;
    logic              enc_q;
    logic [1:0]        src_q;
    logic [7:0]        hdr_q;
    logic [1:0]        ack_id_q;
    logic              err_q;

    logic [1:0]        h_dest;
    logic [1:0]        h_src;
    logic [1:0]        h_op;
    logic              hdr_take;
    logic [LEN_W-1:0]  hdr_len;
    logic              wr_hs;
    logic              rd_hs;
    logic              ack_hit;
    logic              last_beat;
    logic              wd_exp;

    assign h_dest    = bus.in_bus_data[5:4];
    assign h_src     = bus.in_bus_data[3:2];
    assign h_op      = bus.in_bus_data[1:0];
    assign hdr_take  = (h_dest == MEM_ID) && (h_op != OP_HASH);
    assign wr_hs     = (state == S_WDATA) && bus.in_bus_valid
                       && bus.wr_ready;
    assign rd_hs     = (state == S_RDATA) && bus.rd_valid
                       && bus.in_bus_ready;
    assign ack_hit   = bus.in_ack_valid && (bus.in_ack_src == src_q);
    assign last_beat = (cnt == len_q - LEN_W'(1));
    assign wd_exp    = (wd == WD_W'(ACK_TIMEOUT - 1));

    // Beat count implied by the header being presented
    always_comb begin
        hdr_len = '0;
        unique case (1'b1)
            (h_op == OP_KEY):
                hdr_len = LEN_W'(KEY_BEATS);
            ((h_op == OP_TEXT) || (h_op == OP_WR)) && (h_src == SHA_ID):
                hdr_len = LEN_W'(SHA_BEATS);
            ((h_op == OP_TEXT) || (h_op == OP_WR)) && (h_src == AES_ID):
                hdr_len = LEN_W'(AES_BEATS);
            default: hdr_len = '0;
        endcase
    end

    // Transaction FSM with captured command fields, counters and err pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            wd       <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            rw_q     <= 1'b0;
            enc_q    <= 1'b0;
            src_q    <= 2'd0;
            hdr_q    <= 8'd0;
            ack_id_q <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.in_bus_valid && hdr_take) begin
                        hdr_q <= bus.in_bus_data;
                        rw_q  <= (h_op != OP_WR);
                        enc_q <= bus.in_bus_data[7];
                        src_q <= h_src;
                        len_q <= hdr_len;
                        idx   <= '0;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus.in_bus_valid) begin
                        addr_q[idx*8 +: 8] <= bus.in_bus_data;
                        if (idx == IDX_W'(ADDR_BYTES - 1)) begin
                            if (len_q == '0) begin
                                err_q <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                state <= S_ISSUE;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    if (bus.fsm_cmd_ready) begin
                        cnt   <= '0;
                        state <= rw_q ? S_RDATA : S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (wr_hs) begin
                        cnt <= cnt + LEN_W'(1);
                        if (last_beat) begin
                            state <= S_WDONE;
                        end
                    end
                end
                S_WDONE: begin
                    if (bus.fsm_done) begin
                        ack_id_q <= CTRL_ID;
                        state    <= S_ACK_TX;
                    end
                end
                S_RDATA: begin
                    if (rd_hs) begin
                        cnt <= cnt + LEN_W'(1);
                        if (last_beat) begin
                            wd    <= '0;
                            state <= S_ACK_RX;
                        end
                    end
                end
                S_ACK_RX: begin
                    if (ack_hit) begin
                        ack_id_q <= CTRL_ID;
                        state    <= S_ACK_TX;
                    end else if (wd_exp) begin
                        err_q    <= 1'b1;
                        ack_id_q <= CTRL_ID;
                        state    <= S_ACK_TX;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                S_ACK_TX: begin
                    if (bus.in_ack_grant) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore control decodes plus combinational stream passthrough
    always_comb begin
        bus.out_bus_ready = 1'b0;
        bus.out_bus_valid = 1'b0;
        bus.out_bus_data  = hdr_q;
        bus.wr_valid      = 1'b0;
        bus.wr_data       = hdr_q;
        bus.rd_ready      = 1'b0;
        bus.fsm_cmd_valid = 1'b0;
        bus.out_ack_req   = 1'b0;
        case (state)
            S_IDLE:  bus.out_bus_ready = 1'b1;
            S_ADDR:  bus.out_bus_ready = 1'b1;
            S_ISSUE: bus.fsm_cmd_valid = 1'b1;
            S_WDATA: begin
                bus.wr_valid      = bus.in_bus_valid;
                bus.wr_data       = bus.in_bus_data;
                bus.out_bus_ready = bus.wr_ready;
            end
            S_RDATA: begin
                bus.out_bus_valid = bus.rd_valid;
                bus.out_bus_data  = bus.rd_data;
                bus.rd_ready      = bus.in_bus_ready;
            end
            S_ACK_TX: bus.out_ack_req = 1'b1;
            default: ;
        endcase
    end

    assign bus.fsm_rw     = rw_q;
    assign bus.fsm_enc    = enc_q;
    assign bus.fsm_addr   = addr_q;
    assign bus.fsm_len    = len_q;
    assign bus.out_ack_id = ack_id_q;
    assign bus.busy       = (state != S_IDLE);
    assign bus.err        = err_q;
endmodule
